// File: rtl/floo_pkg.sv
// Shared types for the FlooNoC route-computation pipe.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package floo_pkg;

    typedef enum logic [1:0] {
        IdTable       = 2'd0,
        XYRouting     = 2'd1,
        SourceRouting = 2'd2
    } route_algo_e;

    // Target of a config write.
    typedef enum logic {
        CfgRule  = 1'b0,
        CfgRoute = 1'b1
    } cfg_sel_e;

    typedef logic [31:0] floo_addr_t;
    typedef logic [7:0]  floo_route_t;

    // X occupies the low half so XY decode can build the ID as {y, x}.
    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } floo_id_t;

    typedef struct packed {
        floo_id_t   idx;
        floo_addr_t start_addr;
        floo_addr_t end_addr;
    } floo_addr_rule_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/floo_route_decode.sv
// Single-lane address rule match: first enabled rule (lowest index) whose range holds addr.
// Latency: combinational.
// Backpressure: none; pure function of addr and the shared rule registers.
//
// Ports: addr (lookup address), rules/rule_en (shared rule table), id (matched rule
// target, '0 on miss), hit (some enabled rule matched).
module floo_route_decode
    import floo_pkg::*;
#(
    parameter int unsigned NumAddrRules = 8,
    parameter type         id_t         = floo_id_t,
    parameter type         addr_t       = floo_addr_t,
    parameter type         addr_rule_t  = floo_addr_rule_t
) (
    input  addr_t                         addr,
    input  addr_rule_t [NumAddrRules-1:0] rules,
    input  logic       [NumAddrRules-1:0] rule_en,
    output id_t                           id,
    output logic                          hit
);

    // Scan from the top so the lowest matching index is written last and wins.
    always_comb begin
        id  = '0;
        hit = 1'b0;
        for (int i = int'(NumAddrRules) - 1; i >= 0; i--) begin
            if (rule_en[i] && (addr >= rules[i].start_addr) && (addr < rules[i].end_addr)) begin
                id  = rules[i].idx;
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/floo_route_comp_pipe.sv
// Multi-channel route computation: resolves destination ID (and source route) per request.
// Latency: 1 cycle from accept to valid_o, full throughput per channel.
// Backpressure: 1-deep output register per lane; ready_o[c] = !valid_o[c] | ready_i[c].
//
// Ports: valid_i/ready_o/addr_i/id_i request side; valid_o/ready_i/id_o/route_o/dec_err_o
// result side; cfg_* writes the rule table (cfg_sel_i=0) or route table (cfg_sel_i=1);
// err_cnt_o saturating decode-error count, err_clr_i clears it.
module floo_route_comp_pipe
    import floo_pkg::*;
#(
    parameter route_algo_e RouteAlgo     = IdTable,
    parameter bit          UseIdTable    = 1'b1,
    parameter int unsigned NumChannels   = 2,
    parameter int unsigned NumAddrRules  = 8,
    parameter int unsigned NumRoutes     = 16,
    parameter int unsigned XYAddrOffsetX = 0,
    parameter int unsigned XYAddrOffsetY = 0,
    parameter int unsigned IdAddrOffset  = 0,
    parameter int unsigned ErrCntWidth   = 16,
    parameter type         id_t          = floo_id_t,
    parameter type         addr_t        = floo_addr_t,
    parameter type         route_t       = floo_route_t,
    parameter type         addr_rule_t   = floo_addr_rule_t,
    parameter id_t         DefaultId     = '0,
    localparam int unsigned CfgIdxWidth  = max_u(1, $clog2(max_u(NumAddrRules, NumRoutes)))
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic   [NumChannels-1:0]          valid_i,
    output logic   [NumChannels-1:0]          ready_o,
    input  addr_t  [NumChannels-1:0]          addr_i,
    input  id_t    [NumChannels-1:0]          id_i,
    output logic   [NumChannels-1:0]          valid_o,
    input  logic   [NumChannels-1:0]          ready_i,
    output id_t    [NumChannels-1:0]          id_o,
    output route_t [NumChannels-1:0]          route_o,
    output logic   [NumChannels-1:0]          dec_err_o,
    input  logic                              cfg_we_i,
    input  logic                              cfg_sel_i,
    input  logic   [CfgIdxWidth-1:0]          cfg_idx_i,
    input  addr_rule_t                        cfg_rule_i,
    input  logic                              cfg_rule_en_i,
    input  route_t                            cfg_route_i,
    output logic   [ErrCntWidth-1:0]          err_cnt_o,
    input  logic                              err_clr_i
);

    localparam int unsigned IdWidth     = $bits(id_t);
    localparam int unsigned NewErrWidth = $clog2(NumChannels + 1);
    localparam int unsigned SumWidth    = ErrCntWidth + NewErrWidth;

    if ((RouteAlgo != IdTable) && (RouteAlgo != XYRouting) && (RouteAlgo != SourceRouting)) begin : gen_bad_algo
        $fatal(1, "floo_route_comp_pipe: unsupported RouteAlgo");
    end
    if (!UseIdTable && (RouteAlgo == XYRouting) && ((IdWidth % 2) != 0)) begin : gen_bad_xy
        $fatal(1, "floo_route_comp_pipe: XY decode needs an even-width id_t");
    end
    if (!UseIdTable && (IdAddrOffset + IdWidth > $bits(addr_t))) begin : gen_bad_id_off
        $fatal(1, "floo_route_comp_pipe: IdAddrOffset slice outside addr_t");
    end

    // ---------------- Runtime-programmable tables ----------------
    addr_rule_t [NumAddrRules-1:0] rule_q;
    logic       [NumAddrRules-1:0] rule_en_q;
    route_t     [NumRoutes-1:0]    route_tbl_q;

    // Out-of-range indices match no entry, so such writes drop silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rule_q      <= '0;
            rule_en_q   <= '0;
            route_tbl_q <= '0;
        end else if (cfg_we_i) begin
            for (int unsigned i = 0; i < NumAddrRules; i++) begin
                if ((cfg_sel_i == CfgRule) && (32'(cfg_idx_i) == i)) begin
                    rule_q[i]    <= cfg_rule_i;
                    rule_en_q[i] <= cfg_rule_en_i;
                end
            end
            for (int unsigned r = 0; r < NumRoutes; r++) begin
                if ((cfg_sel_i == CfgRoute) && (32'(cfg_idx_i) == r)) begin
                    route_tbl_q[r] <= cfg_route_i;
                end
            end
        end
    end

    // ---------------- Per-channel decode and output register ----------------
    logic [NumChannels-1:0] accept;
    logic [NumChannels-1:0] acc_err;

    for (genvar c = 0; c < NumChannels; c++) begin : gen_lane
        id_t                dec_id;
        logic               dec_hit;
        id_t                lane_id;
        logic               lane_miss;
        logic [IdWidth-1:0] rt_idx;
        route_t             rt_val;
        logic               rt_oob;
        route_t             lane_route;
        logic               lane_err;

        logic               valid_q;
        id_t                id_q;
        route_t             route_q;
        logic               err_q;

        floo_route_decode #(
            .NumAddrRules (NumAddrRules),
            .id_t         (id_t),
            .addr_t       (addr_t),
            .addr_rule_t  (addr_rule_t)
        ) i_decode (
            .addr    (addr_i[c]),
            .rules   (rule_q),
            .rule_en (rule_en_q),
            .id      (dec_id),
            .hit     (dec_hit)
        );

        always_comb begin
            lane_id   = DefaultId;
            lane_miss = 1'b0;
            if (UseIdTable) begin
                lane_id   = dec_hit ? dec_id : DefaultId;
                lane_miss = !dec_hit;
            end else if (RouteAlgo == XYRouting) begin
                lane_id = id_t'({addr_i[c][XYAddrOffsetY +: IdWidth/2],
                                 addr_i[c][XYAddrOffsetX +: IdWidth/2]});
            end else begin
                lane_id = id_t'(addr_i[c][IdAddrOffset +: IdWidth]);
            end

            // Without the ID table the route is looked up by the requester's own ID.
            rt_idx = UseIdTable ? lane_id : id_i[c];
            rt_oob = (32'(rt_idx) >= NumRoutes);
            rt_val = '0;
            for (int unsigned r = 0; r < NumRoutes; r++) begin
                if (32'(rt_idx) == r) rt_val = route_tbl_q[r];
            end

            lane_route = '0;
            lane_err   = lane_miss;
            if (RouteAlgo == SourceRouting) begin
                lane_route = rt_val;
                lane_err   = lane_miss | rt_oob;
            end
        end

        assign ready_o[c] = !valid_q | ready_i[c];
        assign accept[c]  = valid_i[c] & ready_o[c];
        assign acc_err[c] = accept[c] & lane_err;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                id_q    <= '0;
                route_q <= '0;
                err_q   <= 1'b0;
            end else if (accept[c]) begin
                valid_q <= 1'b1;
                id_q    <= lane_id;
                route_q <= lane_route;
                err_q   <= lane_err;
            end else if (ready_i[c]) begin
                valid_q <= 1'b0;
            end
        end

        assign valid_o[c]   = valid_q;
        assign id_o[c]      = id_q;
        assign route_o[c]   = route_q;
        assign dec_err_o[c] = err_q;
    end

    // ---------------- Saturating error counter ----------------
    logic [NewErrWidth-1:0] new_errs;
    logic [ErrCntWidth-1:0] cnt_base;
    logic [SumWidth-1:0]    err_sum;
    logic [ErrCntWidth-1:0] err_cnt_d;
    logic [ErrCntWidth-1:0] err_cnt_q;

    always_comb begin
        new_errs = '0;
        for (int c = 0; c < int'(NumChannels); c++) begin
            new_errs = new_errs + NewErrWidth'(acc_err[c]);
        end
    end

    // Clear wins over the old count, but errors of the clearing cycle still land.
    assign cnt_base  = err_clr_i ? '0 : err_cnt_q;
    assign err_sum   = SumWidth'(cnt_base) + SumWidth'(new_errs);
    assign err_cnt_d = (err_sum > SumWidth'({ErrCntWidth{1'b1}})) ? '1 : err_sum[ErrCntWidth-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_cnt_q <= '0;
        else         err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_floo_route_comp_pipe.sv
// Bench for floo_route_comp_pipe: scoreboard on the ID-table instance plus directed checks.
// Latency: expects results one cycle after accept.
// Backpressure: exercises stalls through ready_i.
module tb_floo_route_comp_pipe;
    import floo_pkg::*;

    localparam int CntW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Main instance: SourceRouting over the ID table, two lanes.
    logic [1:0]        valid_i, ready_o, valid_o, ready_i, dec_err_o;
    floo_addr_t [1:0]  addr_i;
    floo_id_t [1:0]    id_i, id_o;
    floo_route_t [1:0] route_o;
    logic              cfg_we, cfg_sel, cfg_rule_en, err_clr;
    logic [3:0]        cfg_idx;
    floo_addr_rule_t   cfg_rule;
    floo_route_t       cfg_route;
    logic [CntW-1:0]   err_cnt;

    // Second instance: SourceRouting on the requester ID, one lane.
    logic [0:0]        valid_b, ready_ob, valid_ob, ready_ib, dec_err_b;
    floo_addr_t [0:0]  addr_b;
    floo_id_t [0:0]    id_ib, id_ob;
    floo_route_t [0:0] route_ob;
    logic              cfg_we_b, cfg_sel_b, cfg_rule_en_b, err_clr_b;
    logic [3:0]        cfg_idx_b;
    floo_addr_rule_t   cfg_rule_b;
    floo_route_t       cfg_route_b;
    logic [CntW-1:0]   err_cnt_b;

    floo_route_comp_pipe #(
        .RouteAlgo(SourceRouting), .UseIdTable(1'b1), .NumChannels(2), .NumAddrRules(8),
        .NumRoutes(16), .ErrCntWidth(CntW), .DefaultId(floo_id_t'(8'h07))
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .addr_i(addr_i),
        .id_i(id_i), .valid_o(valid_o), .ready_i(ready_i), .id_o(id_o), .route_o(route_o),
        .dec_err_o(dec_err_o), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_idx_i(cfg_idx),
        .cfg_rule_i(cfg_rule), .cfg_rule_en_i(cfg_rule_en), .cfg_route_i(cfg_route),
        .err_cnt_o(err_cnt), .err_clr_i(err_clr)
    );

    floo_route_comp_pipe #(
        .RouteAlgo(SourceRouting), .UseIdTable(1'b0), .NumChannels(1), .NumAddrRules(8),
        .NumRoutes(16), .ErrCntWidth(CntW)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_b), .ready_o(ready_ob), .addr_i(addr_b),
        .id_i(id_ib), .valid_o(valid_ob), .ready_i(ready_ib), .id_o(id_ob), .route_o(route_ob),
        .dec_err_o(dec_err_b), .cfg_we_i(cfg_we_b), .cfg_sel_i(cfg_sel_b), .cfg_idx_i(cfg_idx_b),
        .cfg_rule_i(cfg_rule_b), .cfg_rule_en_i(cfg_rule_en_b), .cfg_route_i(cfg_route_b),
        .err_cnt_o(err_cnt_b), .err_clr_i(err_clr_b)
    );

    int chk_cnt = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- Reference model and scoreboard ----------------
    typedef struct packed {
        floo_id_t    id;
        floo_route_t route;
        logic        err;
    } exp_t;

    floo_addr_rule_t m_rule [8];
    logic            m_en [8];
    floo_route_t     m_route [16];
    int              m_cnt;
    exp_t            sb [2][$];
    exp_t            mon_e;
    int              mon_nerr;

    function automatic exp_t predict(input floo_addr_t a);
        exp_t e;
        int   idx;
        e.id  = floo_id_t'(8'h07);
        e.err = 1'b1;
        e.route = '0;
        for (int i = 0; i < 8; i++) begin
            if (e.err && m_en[i] && a >= m_rule[i].start_addr && a < m_rule[i].end_addr) begin
                e.id  = m_rule[i].idx;
                e.err = 1'b0;
            end
        end
        idx = int'({24'd0, e.id});
        if (idx < 16) e.route = m_route[idx];
        else e.err = 1'b1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb[0].delete();
            sb[1].delete();
            m_cnt = 0;
            for (int i = 0; i < 8; i++) begin m_rule[i] = '0; m_en[i] = 1'b0; end
            for (int r = 0; r < 16; r++) m_route[r] = '0;
        end else begin
            chk("err_cnt", err_cnt, m_cnt);
            mon_nerr = 0;
            for (int c = 0; c < 2; c++) begin
                chk("ready_o", ready_o[c], !valid_o[c] || ready_i[c]);
                if (valid_o[c]) begin
                    if (sb[c].size() == 0) chk("spurious_valid", valid_o[c], 0);
                    else begin
                        mon_e = sb[c][0];
                        chk("id_o", id_o[c], mon_e.id);
                        chk("route_o", route_o[c], mon_e.route);
                        chk("dec_err_o", dec_err_o[c], mon_e.err);
                        if (ready_i[c]) void'(sb[c].pop_front());
                    end
                end
                if (valid_i[c] && ready_o[c]) begin
                    mon_e = predict(addr_i[c]);
                    sb[c].push_back(mon_e);
                    if (mon_e.err) mon_nerr++;
                end
            end
            m_cnt = err_clr ? mon_nerr : ((m_cnt + mon_nerr > 15) ? 15 : m_cnt + mon_nerr);
            if (cfg_we) begin
                if (!cfg_sel && int'(cfg_idx) < 8) begin
                    m_rule[int'(cfg_idx)] = cfg_rule;
                    m_en[int'(cfg_idx)]   = cfg_rule_en;
                end else if (cfg_sel) begin
                    m_route[int'(cfg_idx)] = cfg_route;
                end
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rule_wr(input int idx, input floo_addr_t s, input floo_addr_t e,
                           input logic [7:0] id, input logic en);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 4'(idx);
        cfg_rule.idx = floo_id_t'(id); cfg_rule.start_addr = s; cfg_rule.end_addr = e;
        cfg_rule_en = en;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic route_wr(input int idx, input floo_route_t r);
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 4'(idx); cfg_route = r;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input int ch, input floo_addr_t a);
        valid_i[ch] = 1'b1;
        addr_i[ch]  = a;
        tick();
        valid_i[ch] = 1'b0;
    endtask

    floo_addr_t stream [6] = '{32'h0800, 32'h1800, 32'h2800, 32'h0400, 32'h1400, 32'h3000};
    logic acc;
    int   k, n;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        valid_i = '0; ready_i = '0; addr_i = '0; id_i = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_rule = '0; cfg_rule_en = 1'b0;
        cfg_route = '0; err_clr = 1'b0;
        valid_b = '0; ready_ib = 1'b1; addr_b = '0; id_ib = '0;
        cfg_we_b = 1'b0; cfg_sel_b = 1'b0; cfg_idx_b = '0; cfg_rule_b = '0;
        cfg_rule_en_b = 1'b0; cfg_route_b = '0; err_clr_b = 1'b0;

        repeat (3) tick();
        chk("rst_valid_o", valid_o, 0);
        chk("rst_id_o", id_o, 0);
        chk("rst_route_o", route_o, 0);
        chk("rst_dec_err_o", dec_err_o, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_o", ready_o, 2'b11);
        ready_i = 2'b11;

        // Basic decode
        rule_wr(0, 32'h0000, 32'h1000, 8'h03, 1'b1);
        rule_wr(1, 32'h1000, 32'h2000, 8'h05, 1'b1);
        route_wr(3, 8'h33);
        route_wr(5, 8'h55);
        route_wr(7, 8'h77);
        send(0, 32'h1800);
        chk("hit_id", id_o[0], 8'h05);
        chk("hit_err", dec_err_o[0], 0);
        chk("hit_route", route_o[0], 8'h55);
        send(0, 32'h3000);
        chk("miss_id", id_o[0], 8'h07);
        chk("miss_err", dec_err_o[0], 1);
        chk("miss_route", route_o[0], 8'h77);
        chk("cnt_one", err_cnt, 1);
        valid_i = 2'b11; addr_i[0] = 32'h3000; addr_i[1] = 32'h3000;
        tick();
        valid_i = '0;
        chk("cnt_dual_miss", err_cnt, 3);
        tick();

        // Backpressure on lane 1
        k = 0; n = 0;
        while (k < 6 && n < 40) begin
            valid_i[1] = 1'b1;
            addr_i[1]  = stream[k];
            ready_i[1] = (n < 1 || n > 3);
            @(negedge clk);
            acc = ready_o[1];
            if (n >= 1 && n <= 3) chk("stall_ready_o", ready_o[1], 0);
            @(posedge clk);
            #1;
            if (acc) k++;
            n++;
        end
        if (k < 6) chk("stream_timeout", k, 6);
        valid_i = '0; ready_i = 2'b11;
        repeat (2) tick();
        chk("sb_drain", sb[0].size() + sb[1].size(), 0);

        // Overlapping rules, disable in the accept cycle
        rule_wr(0, 32'h0000, 32'h2000, 8'h02, 1'b1);
        rule_wr(1, 32'h1000, 32'h3000, 8'h04, 1'b1);
        route_wr(2, 8'h22);
        route_wr(4, 8'h44);
        send(0, 32'h1800);
        chk("ovl_id", id_o[0], 8'h02);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 4'd0; cfg_rule_en = 1'b0;
        cfg_rule.idx = floo_id_t'(8'h02); cfg_rule.start_addr = 32'h0; cfg_rule.end_addr = 32'h2000;
        valid_i[0] = 1'b1; addr_i[0] = 32'h1800;
        tick();
        cfg_we = 1'b0; valid_i = '0;
        chk("cfg_same_cycle_id", id_o[0], 8'h02);
        send(0, 32'h1800);
        chk("ovl_dis_id", id_o[0], 8'h04);
        chk("ovl_dis_route", route_o[0], 8'h44);

        // Route index beyond table, ignored rule write beyond table
        rule_wr(2, 32'h8000, 32'h9000, 8'h20, 1'b1);
        send(1, 32'h8800);
        chk("oob_id", id_o[1], 8'h20);
        chk("oob_route", route_o[1], 0);
        chk("oob_err", dec_err_o[1], 1);
        rule_wr(9, 32'h3000, 32'h4000, 8'h01, 1'b1);
        send(0, 32'h3000);
        chk("ign_wr_id", id_o[0], 8'h07);

        // Saturation and clear
        valid_i = 2'b11; addr_i[0] = 32'h3000; addr_i[1] = 32'h3000;
        repeat (10) tick();
        valid_i = '0;
        chk("cnt_sat", err_cnt, 15);
        send(0, 32'h3000);
        chk("cnt_sat_hold", err_cnt, 15);
        err_clr = 1'b1; valid_i[0] = 1'b1; addr_i[0] = 32'h3000;
        tick();
        err_clr = 1'b0; valid_i = '0;
        chk("cnt_clr_with_err", err_cnt, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("cnt_clr", err_cnt, 0);

        // Asynchronous reset mid-burst
        valid_i = 2'b11; addr_i[0] = 32'h1800; addr_i[1] = 32'h3000;
        tick();
        tick();
        chk("pre_arst_valid", valid_o, 2'b11);
        chk("pre_arst_cnt", err_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_o", valid_o, 0);
        chk("arst_cnt", err_cnt, 0);
        valid_i = '0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", ready_o, 2'b11);
        send(0, 32'h1800);
        chk("post_rst_id", id_o[0], 8'h07);
        chk("post_rst_err", dec_err_o[0], 1);
        chk("post_rst_route", route_o[0], 0);
        tick();

        // Route lookup by requester ID
        cfg_we_b = 1'b1; cfg_sel_b = 1'b1; cfg_idx_b = 4'd6; cfg_route_b = 8'hA5;
        tick();
        cfg_we_b = 1'b0;
        valid_b = 1'b1; addr_b[0] = 32'h0000_0012; id_ib[0] = floo_id_t'(8'h06);
        tick();
        valid_b = 1'b0;
        chk("b_route", route_ob[0], 8'hA5);
        chk("b_id", id_ob[0], 8'h12);
        chk("b_err", dec_err_b[0], 0);
        cfg_we_b = 1'b1; cfg_route_b = 8'h5A; valid_b = 1'b1;
        tick();
        cfg_we_b = 1'b0; valid_b = 1'b0;
        chk("b_same_cycle_route", route_ob[0], 8'hA5);
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        chk("b_new_route", route_ob[0], 8'h5A);
        valid_b = 1'b1; id_ib[0] = floo_id_t'(8'h14);
        tick();
        valid_b = 1'b0;
        chk("b_oob_route", route_ob[0], 0);
        chk("b_oob_err", dec_err_b[0], 1);
        chk("b_err_cnt", err_cnt_b, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
